instruction_fetch_stage: RTL and testbench

//  IF stage of the five-stage MIPS pipeline. Owns the PC register and drives it to

---
 rtl/instruction_fetch_stage.sv | 104 ++++++++++
 tb/tb_instruction_fetch_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_stage
//  Description : IF stage of a five-stage MIPS pipeline. Owns the PC, selects
//                next PC (jump > branch > stall > PC+4), latches the fetched
//                word into the IF/ID register, squashes on redirect.
//                Optional macro FETCH_RANGE_CHECK_EN enables a sticky
//                out-of-range fetch fault that freezes the front end.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 56,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        branch_en,
  input  logic [31:0] branch_base,
  input  logic [15:0] branch_offset,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  // Highest byte address at which a full word can still be fetched.
  localparam logic [31:0] c_last_fetch_pc = 32'(IMEM_BYTES - 4);

`ifdef FETCH_RANGE_CHECK_EN
  localparam logic c_range_check_on = 1'b1;
`else
  localparam logic c_range_check_on = 1'b0;
`endif

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic        r_fault;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_redirect_tgt;
  logic        w_redirect;
  logic        w_out_of_range;

  // Target arithmetic; all sums wrap modulo 2^32 and stay word aligned.
  always_comb begin
    w_pc_plus4     = r_pc + 32'd4;
    w_jump_tgt     = {r_pc_plus4[31:28], jump_index, 2'b00};
    w_branch_tgt   = branch_base + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    w_redirect     = jump_en | branch_en;
    w_redirect_tgt = jump_en ? w_jump_tgt : w_branch_tgt;
    w_out_of_range = c_range_check_on & (r_pc > c_last_fetch_pc);
  end

  // PC and IF/ID register update; a latched fault freezes everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else if (r_fault) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (w_redirect) begin
      // Squash the wrong-path word; redirect beats a concurrent stall.
      r_pc       <= w_redirect_tgt;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (stall) begin
      r_pc       <= r_pc;
    end else if (w_out_of_range) begin
      r_fault    <= 1'b1;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else begin
      r_pc       <= w_pc_plus4;
      r_instr    <= imem_instr;
      r_pc_plus4 <= w_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign imem_pc        = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus4 = r_pc_plus4;
  assign if_id_valid    = r_valid;
  assign fetch_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_stage
//  Description : Directed self-checking bench for instruction_fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        stall;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        branch_en;
  logic [31:0] branch_base;
  logic [15:0] branch_offset;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;

  int checks;
  int failures;

  instruction_fetch_stage u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .jump_en        (jump_en),
    .jump_index     (jump_index),
    .branch_en      (branch_en),
    .branch_base    (branch_base),
    .branch_offset  (branch_offset),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word content encodes its own address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign imem_instr = word_at(imem_pc);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks fetch address and the full IF/ID register in one go.
  task automatic chk_state(input string tag, input logic [31:0] pc, input logic v,
                           input logic [31:0] ins, input logic [31:0] p4);
    chk({tag, ".pc"},    imem_pc, pc);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".instr"}, if_id_instr, ins);
    if (v) chk({tag, ".pc4"}, if_id_pc_plus4, p4);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_index = '0;
    branch_en = 1'b0; branch_base = '0; branch_offset = '0;

    // Reset state
    #12;
    chk_state("rst", 32'd0, 1'b0, 32'd0, 32'd0);
    chk("rst.pc4", if_id_pc_plus4, 32'd0);
    chk("rst.fault", {31'd0, fetch_fault}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel.pc", imem_pc, 32'd0);

    // Sequential fetch
    tick(); chk_state("seq1", 32'd4,  1'b1, word_at(0),  32'd4);
    tick(); chk_state("seq2", 32'd8,  1'b1, word_at(4),  32'd8);
    tick(); chk_state("seq3", 32'd12, 1'b1, word_at(8),  32'd12);
    tick(); chk_state("seq4", 32'd16, 1'b1, word_at(12), 32'd16);

    // Jump: {4'h0, 26'h7, 2'b00} = 28
    jump_en = 1'b1; jump_index = 26'h7;
    tick(); jump_en = 1'b0;
    chk_state("jmp", 32'd28, 1'b0, 32'd0, 32'd0);
    tick(); chk_state("jmp.after", 32'd32, 1'b1, word_at(28), 32'd32);

    // Branch forward: 16 + 4*4 = 32
    branch_en = 1'b1; branch_base = 32'd16; branch_offset = 16'h0004;
    tick();
    chk_state("bfwd", 32'd32, 1'b0, 32'd0, 32'd0);
    // Branch backward: 16 + (-1)*4 = 12
    branch_offset = 16'hFFFF;
    tick(); branch_en = 1'b0;
    chk_state("bback", 32'd12, 1'b0, 32'd0, 32'd0);
    tick(); chk_state("bback.after", 32'd16, 1'b1, word_at(12), 32'd16);

    // Get to PC=8 with a real instruction in IF/ID: branch to 4, then step.
    branch_en = 1'b1; branch_base = 32'd4; branch_offset = 16'h0000;
    tick(); branch_en = 1'b0;
    chk("b4.pc", imem_pc, 32'd4);
    tick(); chk_state("pre.stall", 32'd8, 1'b1, word_at(4), 32'd8);

    // Stall for three cycles: everything holds
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_state("stall", 32'd8, 1'b1, word_at(4), 32'd8);
    end
    // Stall + jump: jump wins, bubble inserted (5*4 = 20)
    jump_en = 1'b1; jump_index = 26'h5;
    tick();
    chk_state("stall.jmp", 32'd20, 1'b0, 32'd0, 32'd0);
    // Jump + branch together: jump wins (3*4 = 12, branch would be 100)
    branch_en = 1'b1; branch_base = 32'd100; branch_offset = 16'h0000;
    jump_index = 26'h3;
    tick();
    jump_en = 1'b0; branch_en = 1'b0; stall = 1'b0;
    chk_state("jmp.vs.br", 32'd12, 1'b0, 32'd0, 32'd0);
    tick(); chk_state("resume", 32'd16, 1'b1, word_at(12), 32'd16);

    // Asynchronous reset between edges
    #2; reset = 1'b0;
    #1;
    chk("arst.pc", imem_pc, 32'd0);
    chk("arst.valid", {31'd0, if_id_valid}, 32'd0);
    chk("arst.instr", if_id_instr, 32'd0);
    reset = 1'b1;
    tick(); chk_state("arst.rel", 32'd4, 1'b1, word_at(0), 32'd4);

    // Sequential run to the end of memory
    for (int i = 0; i < 12; i++) tick();
    chk_state("end52", 32'd52, 1'b1, word_at(48), 32'd52);
    tick(); chk_state("end56", 32'd56, 1'b1, word_at(52), 32'd56);
    chk("end56.fault", {31'd0, fetch_fault}, 32'd0);
    tick();
`ifdef FETCH_RANGE_CHECK_EN
    chk_state("fault", 32'd56, 1'b0, 32'd0, 32'd0);
    chk("fault.flag", {31'd0, fetch_fault}, 32'd1);
    jump_en = 1'b1; jump_index = 26'h1;
    tick(); jump_en = 1'b0;
    chk_state("fault.nojmp", 32'd56, 1'b0, 32'd0, 32'd0);
    chk("fault.sticky", {31'd0, fetch_fault}, 32'd1);
`else
    chk_state("nofault", 32'd60, 1'b1, word_at(56), 32'd60);
    chk("nofault.flag", {31'd0, fetch_fault}, 32'd0);
    // Wrap: 0 + (-1)*4 = FFFF_FFFC, then PC+4 wraps to 0
    branch_en = 1'b1; branch_base = 32'd0; branch_offset = 16'hFFFF;
    tick(); branch_en = 1'b0;
    chk("wrap.pc", imem_pc, 32'hFFFF_FFFC);
    tick(); chk_state("wrap", 32'd0, 1'b1, word_at(32'hFFFF_FFFC), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
